// File: rtl/cpu64_l1_writeback.sv
// L1 victim writeback engine: reads a dirty/clean victim line, issues a TileLink C Release(Data),
// waits for ReleaseAck and invalidates the way. Define CPU64_L1_WB_BUF_EN to pre-read TT lines into a buffer.
module cpu64_l1_writeback #(
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 53
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [INDEX_W-1:0] req_index_i,
    input  logic [2:0]         req_way_i,
    input  logic [TAG_W-1:0]   req_tag_i,
    input  logic [1:0]         req_state_i,
    output logic               arr_own_o,
    output logic [INDEX_W-1:0] arr_index_o,
    output logic [2:0]         arr_way_o,
    output logic [2:0]         arr_word_o,
    input  logic [63:0]        arr_rdata_i,
    output logic               arr_we_o,
    output logic [1:0]         arr_state_o,
    output logic [7:0]         arr_be_o,
    output logic [TAG_W-1:0]   arr_tag_o,
    output logic               c_valid_o,
    input  logic               c_ready_i,
    output logic [2:0]         c_opcode_o,
    output logic [2:0]         c_param_o,
    output logic [63:0]        c_address_o,
    output logic [63:0]        c_data_o,
    input  logic               d_valid_i,
    input  logic [2:0]         d_opcode_i,
    output logic               d_ready_o,
    output logic               done_o
);

    localparam logic [1:0] ST_N  = 2'd0;
    localparam logic [1:0] ST_B  = 2'd2 - 2'd1;
    localparam logic [1:0] ST_TT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
`ifdef CPU64_L1_WB_BUF_EN
        S_RD       = 3'd1,
`endif
        S_SEND     = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_INV      = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         beat_q, beat_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic [2:0]         way_q, way_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [1:0]         vstate_q, vstate_d;
    logic               n_done_q, n_done_d;
    logic               is_tt_s;

    assign is_tt_s = (vstate_q == ST_TT);

    // State, beat counter and latched victim fields
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            beat_q   <= 3'd0;
            index_q  <= '0;
            way_q    <= 3'd0;
            tag_q    <= '0;
            vstate_q <= 2'd0;
            n_done_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            index_q  <= index_d;
            way_q    <= way_d;
            tag_q    <= tag_d;
            vstate_q <= vstate_d;
            n_done_q <= n_done_d;
        end
    end

`ifdef CPU64_L1_WB_BUF_EN
    logic [63:0] buf_q [8];

    // Line capture buffer filled one word per RD cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 8; i++) buf_q[i] <= 64'd0;
        end else if (state_q == S_RD) begin
            buf_q[beat_q] <= arr_rdata_i;
        end else begin
            buf_q[beat_q] <= buf_q[beat_q];
        end
    end
`endif

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        index_d  = index_q;
        way_d    = way_q;
        tag_d    = tag_q;
        vstate_d = vstate_q;
        n_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    index_d  = req_index_i;
                    way_d    = req_way_i;
                    tag_d    = req_tag_i;
                    vstate_d = req_state_i;
                    beat_d   = 3'd0;
                    case (req_state_i)
                        ST_N:    n_done_d = 1'b1;
`ifdef CPU64_L1_WB_BUF_EN
                        ST_TT:   state_d = S_RD;
`endif
                        default: state_d = S_SEND;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef CPU64_L1_WB_BUF_EN
            S_RD: begin
                beat_d = beat_q + 3'd1;
                if (beat_q == 3'd7) begin
                    state_d = S_SEND;
                end else begin
                    state_d = S_RD;
                end
            end
`endif
            S_SEND: begin
                // c_valid_o is constant high here, so c_ready_i alone completes a beat
                if (c_ready_i) begin
                    if (is_tt_s) begin
                        beat_d = beat_q + 3'd1;
                    end else begin
                        beat_d = beat_q;
                    end
                    if (!is_tt_s || (beat_q == 3'd7)) begin
                        state_d = S_WAIT_ACK;
                    end else begin
                        state_d = S_SEND;
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
            S_WAIT_ACK: begin
                if (d_valid_i && (d_opcode_i == 3'd6)) begin
                    state_d = S_INV;
                end else begin
                    state_d = S_WAIT_ACK;
                end
            end
            S_INV:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        req_ready_o = 1'b0;
        arr_own_o   = 1'b0;
        arr_index_o = '0;
        arr_way_o   = 3'd0;
        arr_word_o  = 3'd0;
        arr_we_o    = 1'b0;
        arr_state_o = 2'd0;
        arr_be_o    = 8'd0;
        arr_tag_o   = '0;
        c_valid_o   = 1'b0;
        c_opcode_o  = 3'd0;
        c_param_o   = 3'd0;
        c_address_o = 64'd0;
        c_data_o    = 64'd0;
        d_ready_o   = 1'b0;
        done_o      = n_done_q;
        case (state_q)
            S_IDLE: req_ready_o = 1'b1;
`ifdef CPU64_L1_WB_BUF_EN
            S_RD: begin
                arr_own_o   = 1'b1;
                arr_index_o = index_q;
                arr_way_o   = way_q;
                arr_word_o  = beat_q;
            end
`endif
            S_SEND: begin
                c_valid_o   = 1'b1;
                c_opcode_o  = is_tt_s ? 3'd7 : 3'd6;
                c_param_o   = (vstate_q == ST_B) ? 3'd2 : 3'd1;
                c_address_o = {tag_q, index_q, 6'd0};
`ifdef CPU64_L1_WB_BUF_EN
                // TT data already sits in the buffer, so the array is released to other users
                arr_own_o   = !is_tt_s;
                arr_index_o = is_tt_s ? '0 : index_q;
                arr_way_o   = is_tt_s ? 3'd0 : way_q;
                c_data_o    = is_tt_s ? buf_q[beat_q] : 64'd0;
`else
                arr_own_o   = 1'b1;
                arr_index_o = index_q;
                arr_way_o   = way_q;
                arr_word_o  = beat_q;
                c_data_o    = is_tt_s ? arr_rdata_i : 64'd0;
`endif
            end
            S_WAIT_ACK: d_ready_o = 1'b1;
            S_INV: begin
                arr_own_o   = 1'b1;
                arr_we_o    = 1'b1;
                arr_index_o = index_q;
                arr_way_o   = way_q;
                arr_tag_o   = tag_q;
                done_o      = 1'b1;
            end
            default: req_ready_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_cpu64_l1_writeback.sv
// Directed self-checking bench for cpu64_l1_writeback (default and CPU64_L1_WB_BUF_EN builds).
module tb_cpu64_l1_writeback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_index = 5'd0;
    logic [2:0]  req_way = 3'd0;
    logic [52:0] req_tag = 53'd0;
    logic [1:0]  req_state = 2'd0;
    logic        arr_own, arr_we;
    logic [4:0]  arr_index;
    logic [2:0]  arr_way, arr_word;
    logic [63:0] arr_rdata;
    logic [1:0]  arr_state;
    logic [7:0]  arr_be;
    logic [52:0] arr_tag;
    logic        c_valid, c_ready = 1'b0;
    logic [2:0]  c_opcode, c_param;
    logic [63:0] c_address, c_data;
    logic        d_valid = 1'b0;
    logic [2:0]  d_opcode = 3'd0;
    logic        d_ready, done;
    logic [7:0]  gen = 8'h00;

    always #5 clk = ~clk;

    cpu64_l1_writeback #(.INDEX_W(5), .TAG_W(53)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_index_i(req_index),
        .req_way_i(req_way), .req_tag_i(req_tag), .req_state_i(req_state),
        .arr_own_o(arr_own), .arr_index_o(arr_index), .arr_way_o(arr_way), .arr_word_o(arr_word),
        .arr_rdata_i(arr_rdata), .arr_we_o(arr_we), .arr_state_o(arr_state), .arr_be_o(arr_be),
        .arr_tag_o(arr_tag), .c_valid_o(c_valid), .c_ready_i(c_ready), .c_opcode_o(c_opcode),
        .c_param_o(c_param), .c_address_o(c_address), .c_data_o(c_data),
        .d_valid_i(d_valid), .d_opcode_i(d_opcode), .d_ready_o(d_ready), .done_o(done)
    );

    // Array content model: every word is unique per generation, set, way and word
    function automatic logic [63:0] word_val(input logic [7:0] g, input logic [4:0] idx,
                                             input logic [2:0] w, input logic [2:0] wd);
        return {g, 32'hC0FFEE00, 3'b000, idx, 5'b00000, w, 5'b00000, wd};
    endfunction

    assign arr_rdata = word_val(gen, arr_index, arr_way, arr_word);

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor sampled on the falling edge, between input updates and the next rising edge
    logic [63:0] rx_data [$];
    logic [2:0]  rx_op = 3'd0, rx_param = 3'd0;
    logic [63:0] rx_addr = 64'd0;
    int hs_cnt = 0, done_cnt = 0, we_cnt = 0, cv_cnt = 0, own_c_cnt = 0;
    logic        stall_q = 1'b0;
    logic [63:0] st_data = 64'd0, st_addr = 64'd0;
    logic [5:0]  st_oppar = 6'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q) begin
                chk("stall_valid", 64'(c_valid), 64'd1);
                chk("stall_data", c_data, st_data);
                chk("stall_addr", c_address, st_addr);
                chk("stall_oppar", 64'({c_opcode, c_param}), 64'(st_oppar));
            end
            stall_q  <= c_valid && !c_ready;
            st_data  <= c_data;
            st_addr  <= c_address;
            st_oppar <= {c_opcode, c_param};
            if (c_valid) begin
                cv_cnt <= cv_cnt + 1;
                if (arr_own) own_c_cnt <= own_c_cnt + 1;
            end
            if (c_valid && c_ready) begin
                rx_data.push_back(c_data);
                rx_op    <= c_opcode;
                rx_param <= c_param;
                rx_addr  <= c_address;
                hs_cnt   <= hs_cnt + 1;
            end
            if (done)   done_cnt <= done_cnt + 1;
            if (arr_we) we_cnt <= we_cnt + 1;
        end
    end

    int b_hs, b_done, b_we, b_cv, b_own, b_rx;

    task automatic snap();
        b_hs = hs_cnt; b_done = done_cnt; b_we = we_cnt;
        b_cv = cv_cnt; b_own = own_c_cnt; b_rx = rx_data.size();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] st, input logic [4:0] idx, input logic [2:0] w,
                         input logic [52:0] tg);
        req_state = st; req_index = idx; req_way = w; req_tag = tg; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_hs(input int n);
        int k = 0;
        while ((hs_cnt - b_hs) < n && k < 100) begin
            tick();
            k++;
        end
    endtask

    task automatic ack();
        d_valid = 1'b1; d_opcode = 3'd6;
        tick();
        d_valid = 1'b0; d_opcode = 3'd0;
    endtask

    task automatic chk_line(input string tag, input logic [7:0] g, input logic [4:0] idx,
                            input logic [2:0] w);
        chk({tag, "_nwords"}, 64'(rx_data.size() - b_rx), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (b_rx + i < rx_data.size())
                chk({tag, "_word"}, rx_data[b_rx + i], word_val(g, idx, w, 3'(i)));
        end
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_cvalid", 64'(c_valid), 64'd0);
        chk("rst_own", 64'(arr_own), 64'd0);
        chk("rst_we", 64'(arr_we), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dready", 64'(d_ready), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", 64'(req_ready), 64'd1);

        // TT victim, set 3 way 5 tag 1, sink always ready
        snap(); gen = 8'h11; c_ready = 1'b1;
        issue(2'd3, 5'd3, 3'd5, 53'h1);
`ifdef CPU64_L1_WB_BUF_EN
        chk("t1_rd_novalid", 64'(c_valid), 64'd0);
        repeat (8) tick();
`endif
        chk("t1_first_valid", 64'(c_valid), 64'd1);
        wait_hs(8);
        repeat (3) tick();
        chk("t1_beats", 64'(hs_cnt - b_hs), 64'd8);
        chk("t1_dready", 64'(d_ready), 64'd1);
        chk("t1_opcode", 64'(rx_op), 64'd7);
        chk("t1_param", 64'(rx_param), 64'd1);
        chk("t1_addr", rx_addr, 64'h8C0);        // {tag 1, index 3, 6'b0}
        chk_line("t1", 8'h11, 5'd3, 3'd5);
        ack();
        chk("t1_inv_we", 64'(arr_we), 64'd1);
        chk("t1_inv_state", 64'(arr_state), 64'd0);
        chk("t1_inv_be", 64'(arr_be), 64'd0);
        chk("t1_inv_index", 64'(arr_index), 64'd3);
        chk("t1_inv_way", 64'(arr_way), 64'd5);
        chk("t1_inv_tag", 64'(arr_tag), 64'd1);
        chk("t1_inv_done", 64'(done), 64'd1);
        tick();
        chk("t1_done_pulse", 64'(done), 64'd0);
        chk("t1_idle_ready", 64'(req_ready), 64'd1);
        tick();
        chk("t1_done_cnt", 64'(done_cnt - b_done), 64'd1);
        chk("t1_we_cnt", 64'(we_cnt - b_we), 64'd1);

        // TT victim with the sink stalling every other cycle
        snap(); gen = 8'h22; c_ready = 1'b0;
        issue(2'd3, 5'd7, 3'd2, 53'h123);
        for (int k = 0; k < 80 && (hs_cnt - b_hs) < 8; k++) begin
            c_ready = ~c_ready;
            tick();
        end
        c_ready = 1'b1;
        repeat (2) tick();
        chk("t2_beats", 64'(hs_cnt - b_hs), 64'd8);
        chk("t2_addr", rx_addr, 64'h919C0);       // {tag 0x123, index 7, 6'b0}
        chk_line("t2", 8'h22, 5'd7, 3'd2);
        ack();
        tick();
        tick();
        chk("t2_done_cnt", 64'(done_cnt - b_done), 64'd1);

        // B victim; a non-ReleaseAck D beat must be ignored
        snap();
        issue(2'd1, 5'd10, 3'd1, 53'h55);
        wait_hs(1);
        tick();
        chk("t3_beats", 64'(hs_cnt - b_hs), 64'd1);
        chk("t3_opcode", 64'(rx_op), 64'd6);
        chk("t3_param", 64'(rx_param), 64'd2);
        chk("t3_data", rx_data[rx_data.size() - 1], 64'd0);
        d_valid = 1'b1; d_opcode = 3'd4;
        tick();
        d_valid = 1'b0; d_opcode = 3'd0;
        chk("t3_d4_waiting", 64'(d_ready), 64'd1);
        chk("t3_d4_no_we", 64'(arr_we), 64'd0);
        ack();
        chk("t3_inv_we", 64'(arr_we), 64'd1);
        chk("t3_inv_index", 64'(arr_index), 64'd10);
        tick();
        tick();
        chk("t3_we_cnt", 64'(we_cnt - b_we), 64'd1);

        // T victim: Release with TtoN
        snap();
        issue(2'd2, 5'd4, 3'd0, 53'h7);
        wait_hs(1);
        tick();
        chk("t3t_opcode", 64'(rx_op), 64'd6);
        chk("t3t_param", 64'(rx_param), 64'd1);
        chk("t3t_addr", rx_addr, 64'h3900);
        ack();
        tick();

        // N victim: completes immediately with no traffic
        snap();
        issue(2'd0, 5'd9, 3'd3, 53'h9);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_novalid", 64'(c_valid), 64'd0);
        chk("t4_ready", 64'(req_ready), 64'd1);
        tick();
        chk("t4_done_pulse", 64'(done), 64'd0);
        repeat (3) tick();
        chk("t4_cv_cnt", 64'(cv_cnt - b_cv), 64'd0);
        chk("t4_we_cnt", 64'(we_cnt - b_we), 64'd0);
        chk("t4_done_cnt", 64'(done_cnt - b_done), 64'd1);

        // Reset mid-burst, then restart from beat 0
        snap(); gen = 8'h33; c_ready = 1'b1;
        issue(2'd3, 5'd1, 3'd6, 53'h2);
        wait_hs(4);
        chk("t5_mid_valid", 64'(c_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(c_valid), 64'd0);
        chk("t5_rst_own", 64'(arr_own), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_ready", 64'(req_ready), 64'd1);
        snap();
        issue(2'd3, 5'd1, 3'd6, 53'h2);
        wait_hs(8);
        tick();
        chk_line("t5", 8'h33, 5'd1, 3'd6);
        ack();
        tick();

`ifdef CPU64_L1_WB_BUF_EN
        // Buffered TT: array overwritten after capture must not affect the transmitted line
        snap(); gen = 8'h44; c_ready = 1'b1;
        issue(2'd3, 5'd12, 3'd4, 53'hABC);
        chk("t6_rd_own", 64'(arr_own), 64'd1);
        chk("t6_rd_word0", 64'(arr_word), 64'd0);
        repeat (7) tick();
        chk("t6_rd_word7", 64'(arr_word), 64'd7);
        chk("t6_rd_novalid", 64'(c_valid), 64'd0);
        tick();
        gen = 8'h55;
        chk("t6_first_valid", 64'(c_valid), 64'd1);
        chk("t6_send_own", 64'(arr_own), 64'd0);
        wait_hs(8);
        tick();
        chk_line("t6", 8'h44, 5'd12, 3'd4);
        chk("t6_own_during_c", 64'(own_c_cnt - b_own), 64'd0);
        ack();
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
